// File: rtl/adis16209_spi_pkg.sv
// Shared definitions for the ADIS16209 SPI responder: frame field positions,
// derived widths and the frame-control state encoding.
package adis16209_spi_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned W_BIT      = 15;
  localparam int unsigned ADDR_MSB   = 14;
  localparam int unsigned ADDR_LSB   = 8;
  localparam int unsigned DATA_MSB   = 7;

  localparam int unsigned ADDR_W = ADDR_MSB - ADDR_LSB + 1;
  localparam int unsigned DATA_W = DATA_MSB + 1;
  localparam int unsigned CNT_W  = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    WAIT_CS = 2'd0,
    IDLE    = 2'd1,
    SHIFT   = 2'd2,
    HOLD    = 2'd3
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with registered one-cycle
// rise/fall pulses. Pin-to-pulse latency is SYNC_STAGES+1 clk.
// Ports: clk, rst (sync, active high), din (async pin), rise, fall (pulses).
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Synchronizer chain plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {SYNC_STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
      rise  <= chain[SYNC_STAGES-1] & ~prev;
      fall  <= ~chain[SYNC_STAGES-1] & prev;
    end
  end

endmodule

// File: rtl/adis16209_spi_slave.sv
// SPI mode-3 responder emulating the ADIS16209 register interface. Decodes
// 16-bit frames (W, addr[6:0], data[7:0]), issues register-bus writes/reads,
// and returns read data MSB-first during the following frame.
// Ports: clk, rst (sync, active high); sclk, cs_n, mosi (async SPI inputs);
// miso, miso_oe (SPI output); reg_addr, reg_we, reg_wdata, reg_re, reg_rdata
// (register bus); frame_done, frame_err (end-of-frame status pulses).
module adis16209_spi_slave
  import adis16209_spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] IDLE_WORD   = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_we,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_re,
  input  logic [15:0]       reg_rdata,
  output logic              frame_done,
  output logic              frame_err
);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_chain;
  logic mosi_s;

  // sclk idles high; cs_n chain resets to "selected" so that a select
  // already low at reset is never mistaken for a fresh frame.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk_sync (
    .clk (clk),
    .rst (rst),
    .din (sclk),
    .rise(sclk_rise),
    .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_cs_sync (
    .clk (clk),
    .rst (rst),
    .din (cs_n),
    .rise(cs_rise),
    .fall(cs_fall)
  );

  // mosi is only sampled on sclk_rise, so plain synchronization suffices.
  always_ff @(posedge clk) begin
    if (rst) mosi_chain <= '0;
    else     mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_chain[SYNC_STAGES-1];

  state_e            state_q, state_d;
  logic [15:0]       tx_q, tx_d, rx_q, rx_d, rx_next;
  logic [15:0]       resp_q, resp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              overrun_q, overrun_d;
  logic              rd_pending_q;
  logic              decode;
  logic              miso_d, oe_d, we_d, re_d, done_d, err_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    resp_d    = resp_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
    miso_d    = miso;
    addr_d    = reg_addr;
    wdata_d   = reg_wdata;
    we_d      = 1'b0;
    re_d      = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    decode    = 1'b0;
    rx_next   = {rx_q[14:0], mosi_s};

    // Read data arrives the cycle after reg_re; capture it for the next frame.
    if (rd_pending_q) resp_d = reg_rdata;

    case (state_q)
      // Leave only after cs_n is seen high, so an interrupted frame is dropped.
      WAIT_CS: if (cs_rise) state_d = IDLE;
      IDLE: begin
        if (cs_fall) begin
          tx_d      = resp_q;
          cnt_d     = '0;
          overrun_d = 1'b0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_fall) begin
          miso_d = tx_q[15];
          tx_d   = {tx_q[14:0], 1'b0};
        end
        if (sclk_rise) begin
          rx_d  = rx_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
            decode  = 1'b1;
            state_d = HOLD;
          end
        end
        // A cs_rise coinciding with the 16th rise still completes the frame.
        if (cs_rise) begin
          done_d  = decode;
          err_d   = ~decode;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (sclk_rise) overrun_d = 1'b1;
        if (cs_rise) begin
          err_d   = overrun_q | sclk_rise;
          done_d  = ~(overrun_q | sclk_rise);
          state_d = IDLE;
        end
      end
      default: state_d = WAIT_CS;
    endcase

    if (decode) begin
      addr_d = rx_next[ADDR_MSB:ADDR_LSB];
      if (rx_next[W_BIT]) begin
        we_d    = 1'b1;
        wdata_d = rx_next[DATA_MSB:0];
        resp_d  = IDLE_WORD;
      end else begin
        re_d = 1'b1;
      end
    end

    oe_d = (state_d == SHIFT) || (state_d == HOLD);
    if (!oe_d) miso_d = 1'b0;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_CS;
      tx_q         <= '0;
      rx_q         <= '0;
      resp_q       <= IDLE_WORD;
      cnt_q        <= '0;
      overrun_q    <= 1'b0;
      rd_pending_q <= 1'b0;
      miso         <= 1'b0;
      miso_oe      <= 1'b0;
      reg_addr     <= '0;
      reg_wdata    <= '0;
      reg_we       <= 1'b0;
      reg_re       <= 1'b0;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      resp_q       <= resp_d;
      cnt_q        <= cnt_d;
      overrun_q    <= overrun_d;
      rd_pending_q <= reg_re;
      miso         <= miso_d;
      miso_oe      <= oe_d;
      reg_addr     <= addr_d;
      reg_wdata    <= wdata_d;
      reg_we       <= we_d;
      reg_re       <= re_d;
      frame_done   <= done_d;
      frame_err    <= err_d;
    end
  end

endmodule

// File: doc/adis16209_spi_slave.md
# adis16209_spi_slave

SPI mode-3 responder that emulates the ADIS16209 serial register interface on the sensor side of the link. It decodes 16-bit full-duplex frames from an SPI master, issues byte writes and word reads on a simple internal register bus, and returns read data MSB-first in the following frame, matching the part's pipelined read protocol. It is used as the sensor model in system benches and as a loopback target for the master-side SPI logic.

## Interface
Parameters:
- SYNC_STAGES, 2: flip-flop synchronizer depth for sclk, cs_n and mosi.
- IDLE_WORD, 16'h0000: MISO word for the first frame after reset and for the frame following a write.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- sclk  in  1  SPI clock, asynchronous to clk, idles high.
- cs_n  in  1  SPI chip select, active low, asynchronous.
- mosi  in  1  master-out data, sampled on rising sclk.
- miso  out  1  slave-out data, changes on falling sclk; 0 when miso_oe=0.
- miso_oe  out  1  high while a frame is in progress.
- reg_addr  out  7  register byte address (frame bits 14:8).
- reg_we  out  1  one-cycle write strobe.
- reg_wdata  out  8  write byte (frame bits 7:0).
- reg_re  out  1  one-cycle read strobe.
- reg_rdata  in  16  read word; valid the cycle after reg_re.
- frame_done  out  1  one-cycle pulse on cs_n rise after exactly 16 bits.
- frame_err  out  1  one-cycle pulse on cs_n rise after a bit count other than 16.

## Operation
- Frame format: bit 15 is W (1 = write, 0 = read), bits 14:8 are the address, and bits 7:0 are the write data (ignored on reads).
- sclk and cs_n pass through sync plus edge detect, producing sclk_rise, sclk_fall, cs_fall and cs_rise. mosi is synchronized only.
- States: WAIT_CS (reset state), IDLE, SHIFT, HOLD.
- WAIT_CS: go to IDLE once synced cs_n is high. A reset during an active frame never resumes that frame.
- IDLE: on cs_fall, load tx_shift from resp_word, clear bit_cnt, and go to SHIFT.
- SHIFT:
  - On sclk_fall, set miso to tx_shift[15] and shift tx_shift left.
  - On sclk_rise, set rx_shift to {rx_shift[14:0], mosi} and increment bit_cnt.
  - On the 16th rise, decode the frame and go to HOLD.
- Write decode: reg_we=1, reg_addr=rx[14:8], reg_wdata=rx[7:0]. resp_word becomes IDLE_WORD.
- Read decode: reg_re=1 and reg_addr=rx[14:8]. On the next cycle, resp_word captures reg_rdata.
- HOLD: further sclk_rise events set an overrun flag; no second access is issued.
- cs_rise:
  - In HOLD without overrun: frame_done pulse.
  - In HOLD with overrun: frame_err pulse. The access already issued stands.
  - In SHIFT (short frame): frame_err pulse, no register access, resp_word unchanged.
  - In every case, return to IDLE.
- miso_oe is 1 in SHIFT and HOLD and 0 otherwise.
- Reset values: miso=0, miso_oe=0, reg_we=0, reg_re=0, reg_addr=0, reg_wdata=0, frame_done=0, frame_err=0, resp_word=IDLE_WORD.

## Timing
- Pin-to-event latency is SYNC_STAGES+1 clk, i.e. 3 clk at the default.
- miso updates 1 clk after a detected sclk_fall.
- reg_we and reg_re assert 1 clk after the 16th detected sclk_rise.
- resp_word is loaded 1 clk after reg_re.
- frame_done and frame_err assert 1 clk after the detected cs_rise.
- Master requirements:
  - sclk high and low phases of at least 6 clk each. 8/8 at clk/16 is the nominal case.
  - At least 4 clk from cs_n fall to the first sclk fall.
  - At least 4 clk from the last sclk rise to cs_n rise.
  - cs_n high for at least 4 clk between frames.
- The read-data path from reg_re to resp_word is 2 clk. It must complete before the next cs_fall, which is guaranteed by the cs_n high time.
- A simultaneous cs_rise and 16th sclk_rise in the same clk counts as a complete frame: the access is issued and frame_done pulses.

## Structure
- Package adis16209_spi_pkg:
  - State enum.
  - FRAME_BITS=16.
  - W_BIT=15.
  - ADDR_MSB=14, ADDR_LSB=8.
  - DATA_MSB=7.
- Sub-module spi_sync_edge, parameterized by SYNC_STAGES: a synchronizer with registered rise/fall pulses. It is instanced for sclk and cs_n; mosi uses a plain synchronizer.
- The register bank is external to this block.

## Test plan
- After reset: miso=0, miso_oe=0. Send read frame 16'h0400. Required: MISO returns 16'h0000, reg_re pulses once with reg_addr=7'h04, then frame_done pulses.
- Next frame 16'h0600 with the bank returning 16'h1234 for address 7'h04. Required: MISO shifts 16'h1234 MSB-first; reg_re with reg_addr=7'h06.
- Write frame 16'hB6A5. Required: one reg_we with reg_addr=7'h36 and reg_wdata=8'hA5, no reg_re; the following frame's MISO is 16'h0000.
- Short frame: cs_n rises after 9 sclk cycles. Required: frame_err pulse, no strobes; the next frame's MISO repeats the prior resp_word.
- Assert rst after 5 bits with cs_n held low; continue clocking sclk. Required: no strobes and miso_oe=0. After cs_n rises, a fresh 16'h0400 frame behaves as in the first scenario.
- 17 sclk cycles in one frame. Required: a single access at the 16th rise, then frame_err and no frame_done at cs_n rise.
